// File: rtl/ext_sram_target.sv
// ext_sram_target: responder for the multiplexed external SRAM bus, backing a window of the 32-bit space with a 16-bit word memory.
// Optional macro EXT_SRAM_TARGET_PROTO_CHECK_EN adds a sticky err output flagging bus protocol violations.
module ext_sram_target #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] din,
  input  logic        ale0,
  input  logic        ale1,
  input  logic        oe,
  input  logic        we,
  input  logic        bhe,
  output logic [15:0] dout,
  output logic        drive,
  output logic        hit,
  output logic        done
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
  ,
  output logic        err
`endif
);
  typedef enum logic [2:0] {IDLE, ALO, AHI, D1, D2, END} state_t;
  state_t              r_state;
  logic                r_ale0_q;
  logic [15:0]         r_a_lo;
  logic [14:0]         r_a_hi;
  logic                r_ble;
  logic                r_hit;
  logic [15:0]         r_dout;
  logic                r_drive;
  logic                r_done;
  logic [15:0]         r_mem [2**ADDR_W];
  logic                w_rise;
  logic                w_fall;
  logic [32:0]         w_diff;
  logic                w_in;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_wr;
  assign w_rise = ale0 & ~r_ale0_q;
  assign w_fall = ~ale0 & r_ale0_q;
  // the high address half is still on din when hit is decided, so the compare uses din directly
  assign w_diff = {1'b0, din[14:0], r_a_lo, 1'b0} - {1'b0, BASE};
  assign w_in   = w_diff < (33'd1 << (ADDR_W + 1));
  assign w_idx  = ADDR_W'({r_a_hi, r_a_lo} - BASE[31:1]);
  assign w_wr   = (r_state == D2) & we & r_hit & ~w_rise;
  assign dout   = r_dout;
  assign drive  = r_drive;
  assign hit    = r_hit;
  assign done   = r_done;
  // word memory, byte lanes written independently; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr & bhe) r_mem[w_idx][15:8] <= din[15:8];
    if (w_wr & r_ble) r_mem[w_idx][7:0] <= din[7:0];
  end
  // transaction sequencer; a new ale0 rise restarts the address phase from any state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_ale0_q <= 1'b0;
      r_a_lo   <= '0;
      r_a_hi   <= '0;
      r_ble    <= 1'b0;
      r_hit    <= 1'b0;
      r_dout   <= '0;
      r_drive  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ale0_q <= ale0;
      r_done   <= 1'b0;
      if (w_rise) begin
        r_state <= ALO;
        r_drive <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          ALO: if (w_fall) begin
            r_a_lo  <= din;
            r_state <= AHI;
          end
          AHI: if (ale1) begin
            r_ble   <= din[15];
            r_a_hi  <= din[14:0];
            r_hit   <= w_in;
            r_state <= D1;
          end
          D1: begin
            if (oe & ~we & r_hit) begin
              r_dout  <= r_mem[w_idx];
              r_drive <= 1'b1;
            end
            r_state <= D2;
          end
          D2: begin
            if (we) r_drive <= 1'b0;
            if (we | ~oe) r_state <= END;
          end
          END: begin
            r_drive <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
  logic r_err;
  assign err = r_err;
  // sticky protocol error flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err <= 1'b0;
    else if ((oe & (r_state == ALO || r_state == AHI)) | (we & oe) |
             (ale1 & (r_state == ALO)) | (w_rise & (r_state != IDLE))) r_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_ext_sram_target.sv
// tb_ext_sram_target: directed bench driving two targets (windows at 0x0 and 0x1000) on one shared bus.
module tb_ext_sram_target;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] din = '0;
  logic        ale0 = 1'b0, ale1 = 1'b0, oe = 1'b0, we = 1'b0, bhe = 1'b0;
  logic [15:0] d_dout, f_dout;
  logic        d_drive, d_hit, d_done, f_drive, f_hit, f_done;
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
  logic        d_err, f_err;
`endif
  int n_pass = 0;
  int n_tot = 0;
  int n_done = 0;

  ext_sram_target #(.ADDR_W(10), .BASE(32'h0000_0000)) u_dut (
    .clk(clk), .rstn(rstn), .din(din), .ale0(ale0), .ale1(ale1), .oe(oe), .we(we), .bhe(bhe),
    .dout(d_dout), .drive(d_drive), .hit(d_hit), .done(d_done)
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
    , .err(d_err)
`endif
  );

  ext_sram_target #(.ADDR_W(10), .BASE(32'h0000_1000)) u_far (
    .clk(clk), .rstn(rstn), .din(din), .ale0(ale0), .ale1(ale1), .oe(oe), .we(we), .bhe(bhe),
    .dout(f_dout), .drive(f_drive), .hit(f_hit), .done(f_done)
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
    , .err(f_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (d_done) n_done++;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input logic [31:0] a, input logic b_lo);
    ale0 = 1'b1; cyc;
    ale0 = 1'b0; din = a[16:1]; cyc;
    ale1 = 1'b1; din = {b_lo, a[31:17]}; cyc;
    ale1 = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic b_lo, input logic b_hi, input logic [15:0] d);
    addr(a, b_lo);
    we = 1'b1; bhe = b_hi; din = d; cyc;
    cyc;
    we = 1'b0; bhe = 1'b0; cyc;
    n_tot++; if (d_done !== 1'b1) $display("FAIL wr_done_d a=%h got %b want 1", a, d_done); else n_pass++;
    n_tot++; if (f_done !== 1'b1) $display("FAIL wr_done_f a=%h got %b want 1", a, f_done); else n_pass++;
    cyc;
  endtask

  task automatic rd(input logic [31:0] a, input logic dh, input logic fh,
                    input logic [15:0] dv, input logic [15:0] fv, input logic [15:0] m);
    addr(a, 1'b1);
    n_tot++; if (d_hit !== dh) $display("FAIL rd_hit_d a=%h got %b want %b", a, d_hit, dh); else n_pass++;
    n_tot++; if (f_hit !== fh) $display("FAIL rd_hit_f a=%h got %b want %b", a, f_hit, fh); else n_pass++;
    oe = 1'b1; cyc;
    n_tot++; if (d_drive !== dh) $display("FAIL rd_drive_d a=%h got %b want %b", a, d_drive, dh); else n_pass++;
    n_tot++; if (f_drive !== fh) $display("FAIL rd_drive_f a=%h got %b want %b", a, f_drive, fh); else n_pass++;
    if (dh) begin
      n_tot++; if ((d_dout & m) !== (dv & m)) $display("FAIL rd_dout_d a=%h got %h want %h", a, d_dout & m, dv & m); else n_pass++;
    end
    if (fh) begin
      n_tot++; if ((f_dout & m) !== (fv & m)) $display("FAIL rd_dout_f a=%h got %h want %h", a, f_dout & m, fv & m); else n_pass++;
    end
    cyc;
    n_tot++; if (d_drive !== dh) $display("FAIL rd_hold_d a=%h got %b want %b", a, d_drive, dh); else n_pass++;
    oe = 1'b0; cyc;
    cyc;
    n_tot++; if ({d_drive, f_drive} !== 2'b00) $display("FAIL rd_idle_drive a=%h got %b want 00", a, {d_drive, f_drive}); else n_pass++;
    n_tot++; if ({d_done, f_done} !== 2'b11) $display("FAIL rd_done a=%h got %b want 11", a, {d_done, f_done}); else n_pass++;
    cyc;
    n_tot++; if (d_done !== 1'b0) $display("FAIL rd_done_pulse a=%h got %b want 0", a, d_done); else n_pass++;
  endtask

  task automatic test_reset;
    #3;
    n_tot++; if ({d_drive, d_done, d_hit} !== 3'b000) $display("FAIL reset_flags got %b want 000", {d_drive, d_done, d_hit}); else n_pass++;
    n_tot++; if (d_dout !== 16'h0000) $display("FAIL reset_dout got %h want 0000", d_dout); else n_pass++;
    n_tot++; if ({f_drive, f_done, f_hit} !== 3'b000) $display("FAIL reset_flags_f got %b want 000", {f_drive, f_done, f_hit}); else n_pass++;
    cyc; cyc;
    rstn = 1'b1;
    cyc;
  endtask

  task automatic test_write_read;
    wr(32'h0000_0010, 1'b1, 1'b0, 16'h005A);
    rd(32'h0000_0010, 1'b1, 1'b0, 16'h005A, 16'h0000, 16'h00FF);
  endtask

  task automatic test_high_byte;
    wr(32'h0000_0011, 1'b0, 1'b1, 16'hC300);
    rd(32'h0000_0010, 1'b1, 1'b0, 16'hC35A, 16'h0000, 16'hFFFF);
  endtask

  task automatic test_window;
    wr(32'h0000_1010, 1'b1, 1'b1, 16'hBEEF);
    wr(32'h0000_0810, 1'b1, 1'b1, 16'h1111);
    rd(32'h0000_0800, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF);
    rd(32'h0000_1010, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 16'hFFFF);
    rd(32'h0000_0010, 1'b1, 1'b0, 16'hC35A, 16'h0000, 16'hFFFF);
  endtask

  task automatic test_abort;
    int base_done;
    wr(32'h0000_0020, 1'b1, 1'b1, 16'hAAAA);
    base_done = n_done;
    addr(32'h0000_0020, 1'b1);
    we = 1'b1; bhe = 1'b1; din = 16'h5555; ale0 = 1'b1; cyc;
    n_tot++; if (d_drive !== 1'b0) $display("FAIL abort_drive got %b want 0", d_drive); else n_pass++;
    we = 1'b0; bhe = 1'b0; ale0 = 1'b0; din = 16'h0011; cyc;
    ale1 = 1'b1; din = 16'h8000; cyc;
    ale1 = 1'b0; we = 1'b1; bhe = 1'b1; din = 16'h7777; cyc;
    cyc;
    we = 1'b0; bhe = 1'b0; cyc;
    cyc;
    n_tot++; if (n_done - base_done !== 1) $display("FAIL abort_done_count got %0d want 1", n_done - base_done); else n_pass++;
    rd(32'h0000_0020, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 16'hFFFF);
    rd(32'h0000_0022, 1'b1, 1'b0, 16'h7777, 16'h0000, 16'hFFFF);
  endtask

  task automatic test_async_reset;
    addr(32'h0000_0010, 1'b1);
    oe = 1'b1; cyc;
    n_tot++; if (d_drive !== 1'b1) $display("FAIL areset_pre_drive got %b want 1", d_drive); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_tot++; if ({d_drive, d_done, d_hit} !== 3'b000) $display("FAIL areset_flags got %b want 000", {d_drive, d_done, d_hit}); else n_pass++;
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
    n_tot++; if (d_err !== 1'b0) $display("FAIL areset_err got %b want 0", d_err); else n_pass++;
`endif
    oe = 1'b0;
    #1 rstn = 1'b1;
    cyc;
    n_tot++; if (d_drive !== 1'b0) $display("FAIL areset_after got %b want 0", d_drive); else n_pass++;
    rd(32'h0000_0010, 1'b1, 1'b0, 16'hC35A, 16'h0000, 16'hFFFF);
  endtask

`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
  task automatic test_proto;
    n_tot++; if (d_err !== 1'b0) $display("FAIL proto_clean got %b want 0", d_err); else n_pass++;
    addr(32'h0000_0030, 1'b1);
    we = 1'b1; oe = 1'b1; bhe = 1'b1; din = 16'h9ABC; cyc;
    n_tot++; if (d_drive !== 1'b0) $display("FAIL proto_drive got %b want 0", d_drive); else n_pass++;
    cyc;
    we = 1'b0; oe = 1'b0; bhe = 1'b0; cyc;
    n_tot++; if (d_err !== 1'b1) $display("FAIL proto_err got %b want 1", d_err); else n_pass++;
    cyc;
    rd(32'h0000_0030, 1'b1, 1'b0, 16'h9ABC, 16'h0000, 16'hFFFF);
    n_tot++; if (d_err !== 1'b1) $display("FAIL proto_sticky got %b want 1", d_err); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_tot++; if (d_err !== 1'b0) $display("FAIL proto_clear got %b want 0", d_err); else n_pass++;
    rstn = 1'b1;
    cyc;
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_high_byte;
    test_window;
    test_abort;
    test_async_reset;
`ifdef EXT_SRAM_TARGET_PROTO_CHECK_EN
    test_proto;
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ext_sram_target.md
Name: ext_sram_target

Overview:
- Responder end of the external multiplexed SRAM bus.
- Same clock domain as the bus initiator; used for FPGA loopback and system simulation.
- Decodes the two-phase address: ALE0 carries A[16:1], ALE1 carries {BLE, A[31:17]}.
- Backs a window of the 32-bit space with an internal word memory; services byte reads/writes using OE/WE/BHE/BLE; drives read data onto the shared 16-bit bus.

Parameters:
- ADDR_W, 10, word-address bits of internal memory (depth 2^ADDR_W x 16).
- BASE, 32'h0000_0000, window base byte address; must be aligned to 2^(ADDR_W+1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- din  in  16  shared bus as driven by initiator.
- ale0  in  1  address latch enable, low half.
- ale1  in  1  address latch enable, high half.
- oe  in  1  output enable (read), active high.
- we  in  1  write enable, active high.
- bhe  in  1  byte-high enable, active high.
- dout  out  16  read data toward bus.
- drive  out  1  target owns bus (tristate enable for dout).
- hit  out  1  latched address is inside window.
- done  out  1  one-cycle pulse at end of each transaction.

Behaviour:
- Reset (async, rstn=0): state IDLE; dout=0, drive=0, hit=0, done=0; address/BLE regs=0; ale0_q=0; memory contents not reset.
- ale0_q = ale0 registered; rise = ale0 & !ale0_q; fall = !ale0 & ale0_q.
- States: IDLE, ALO, AHI, D1, D2, END.
- IDLE: rise -> ALO.
- ALO: on fall, latch a_lo=din (A[16:1]) -> AHI.
- AHI: first posedge with ale1=1, latch ble=din[15], a_hi=din[14:0].
  - hit <= ({a_hi,a_lo,1'b0} - BASE) < 2^(ADDR_W+1), evaluated as an unsigned 33-bit compare.
  - -> D1.
- D1, read (oe=1 & hit): dout <= mem[a_lo[ADDR_W-1:0]], drive <= 1 (visible from D2). Always -> D2.
- D2, read: keep dout/drive while oe=1.
- D2, write (we=1 & hit):
  - bhe=1 -> mem[idx][15:8] <= din[15:8].
  - ble=1 -> mem[idx][7:0] <= din[7:0].
  - bhe=0 & ble=0 -> no write.
  - -> END.
- END: drive <= 0, done <= 1 for exactly one cycle -> IDLE. drive never stays high into IDLE.
- idx uses {a_hi,a_lo} offset from BASE, low ADDR_W bits.
- Miss (hit=0): no memory access, drive stays 0, done still pulses.
- oe and we both high in D1/D2: write wins, drive=0.
- rise in any non-IDLE state aborts: drive <= 0, no write, no done, -> ALO.
- ale1 may stay high between transactions; only a rise on ale0 starts a new address phase.
- Reset mid-transaction: immediate return to IDLE with drive=0; no partial write.
- Latency: read data on dout 1 cycle after entering D1; write committed at D2 posedge.

Optional Feature:
- Macro: EXT_SRAM_TARGET_PROTO_CHECK_EN.
- Defined: adds output err (1 bit, reset 0, sticky until rstn).
- err sets on any of:
  - oe=1 while in ALO/AHI;
  - we=1 & oe=1 in the same cycle;
  - ale1=1 while in ALO;
  - an abort by rise.
- Not defined: port err absent, no checking logic; all other behaviour identical.

Test Plan:
- Write then read:
  - write byte 0x5A to 0x0000_0010 (ble, din=0x005A);
  - read 0x0000_0010 -> dout[7:0]=0x5A, drive high from D2 until END;
  - done pulses once per transaction.
- High byte: write 0xC3 to 0x0000_0011 (bhe, din=0xC300) after the previous write -> read word idx 8 = 0xC35A.
- Out of window: BASE=0x0000_1000, ADDR_W=10, read 0x0000_0800 -> hit=0, drive=0 throughout, done pulses, memory unchanged.
- Abort: second ale0 rise during D1 of a write -> no write to the first address, no done for it, second transaction completes normally.
- Async reset: rstn low during D2 of a read -> drive=0 and done=0 in the same cycle, state IDLE; next transaction works.
- With EXT_SRAM_TARGET_PROTO_CHECK_EN: oe and we high together in D2 -> err=1 and stays 1 until rstn; memory written (write wins).
